pkt_readout_ctrl: RTL and testbench

Sequencer for the receive path between the 64-bit packet register and the SPI byte buffer. On each packet-received strobe it loads the packet register, shifts the packet out serially eight bits at a time into the SPI byte buffer, and presents each byte to the SPI slave with a ready/ack handshake. It also reports packet-pending, completion, overrun of back-to-back packets and master-side aborts.

---
 rtl/pkt_readout_ctrl_if.sv | 31 +++
 rtl/pkt_readout_ctrl.sv | 113 +++++++++++
 tb/tb_pkt_readout_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_readout_ctrl_if.sv
// Bus between the packet readout sequencer and its peers (packet register,
// SPI byte buffer, SPI slave, status).
interface pkt_readout_ctrl_if #(
  parameter int BL_W = 4
);
  logic            pkt_rec;
  logic            cs;
  logic            byte_ack;
  logic            ovr_clr;
  logic            pkt_flg;
  logic            shift_en;
  logic            byte_flg;
  logic            irq;
  logic            done;
  logic            aborted;
  logic            overrun;
  logic [BL_W-1:0] bytes_left;
  logic [1:0]      state_dbg;

  modport master (
    input  pkt_rec, cs, byte_ack, ovr_clr,
    output pkt_flg, shift_en, byte_flg, irq, done, aborted, overrun,
           bytes_left, state_dbg
  );

  modport slave (
    output pkt_rec, cs, byte_ack, ovr_clr,
    input  pkt_flg, shift_en, byte_flg, irq, done, aborted, overrun,
           bytes_left, state_dbg
  );
endinterface

// File: rtl/pkt_readout_ctrl.sv
// Receive-path sequencer: loads the packet register, shifts it out a byte at a
// time into the SPI byte buffer and hands each byte to the SPI slave.
module pkt_readout_ctrl #(
  parameter int PKT_BITS  = 64,
  parameter int BYTE_BITS = 8
) (
  input logic               clk,
  input logic               rst,
  pkt_readout_ctrl_if.master bus
);
  localparam int NBYTES = PKT_BITS / BYTE_BITS;
  localparam int BL_W   = $clog2(NBYTES) + 1;
  localparam int BIT_W  = $clog2(BYTE_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BL_W-1:0]  bytes_left_q;
  logic             cs_q;
  logic             done_q, aborted_q, overrun_q;

  logic ack, cs_rise, abort, last_ack, byte_end, ovr_set;

  // Handshake: byte_flg is the valid, held high in HOLD until the slave
  // returns byte_ack while cs is low; that cycle is the transfer.
  always_comb begin
    ack      = (state_q == HOLD) && bus.byte_ack && !bus.cs;
    last_ack = ack && (bytes_left_q == BL_W'(1));
    cs_rise  = bus.cs && !cs_q;
    abort    = ((state_q == SHIFT) || (state_q == HOLD)) && cs_rise &&
               (bytes_left_q < BL_W'(NBYTES));
    byte_end = (state_q == SHIFT) && (bit_cnt_q == BIT_W'(BYTE_BITS - 1));
    // A strobe landing on the final ack is taken as the next packet.
    ovr_set  = bus.pkt_rec && (state_q != IDLE) && !last_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.pkt_rec) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        if (abort)         state_d = IDLE;
        else if (byte_end) state_d = HOLD;
      end
      HOLD: begin
        if (abort)         state_d = IDLE;
        else if (last_ack) state_d = bus.pkt_rec ? LOAD : IDLE;
        else if (ack)      state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pkt_flg   = 1'b0;
    bus.shift_en  = 1'b0;
    bus.byte_flg  = 1'b0;
    bus.irq       = 1'b0;
    case (state_q)
      LOAD:  begin bus.pkt_flg  = 1'b1; bus.irq = 1'b1; end
      SHIFT: begin bus.shift_en = 1'b1; bus.irq = 1'b1; end
      HOLD:  begin bus.byte_flg = 1'b1; bus.irq = 1'b1; end
      default: ;
    endcase
    bus.done       = done_q;
    bus.aborted    = aborted_q;
    bus.overrun    = overrun_q;
    bus.bytes_left = bytes_left_q;
    bus.state_dbg  = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      bytes_left_q <= '0;
      cs_q         <= 1'b1;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cs_q      <= bus.cs;
      done_q    <= last_ack;
      aborted_q <= abort;
      if (ovr_set)          overrun_q <= 1'b1;
      else if (bus.ovr_clr) overrun_q <= 1'b0;

      if (state_q == LOAD)  bit_cnt_q <= '0;
      else if (byte_end)    bit_cnt_q <= '0;
      else if (state_q == SHIFT) bit_cnt_q <= bit_cnt_q + BIT_W'(1);

      if (state_q == LOAD) bytes_left_q <= BL_W'(NBYTES);
      else if (ack)        bytes_left_q <= bytes_left_q - BL_W'(1);

      // An abandoned packet leaves the counters as if never started.
      if (abort) begin
        bit_cnt_q    <= '0;
        bytes_left_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pkt_readout_ctrl.sv
// Directed bench for pkt_readout_ctrl: single packet timing, ack gating,
// overrun, back-to-back, abort and mid-packet reset.
module tb_pkt_readout_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pkt_readout_ctrl_if #(.BL_W(4)) bus ();

  pkt_readout_ctrl #(.PKT_BITS(64), .BYTE_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    bus.pkt_rec = 1'b1;
    tick();
    bus.pkt_rec = 1'b0;
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!bus.byte_flg && n < 50) begin
      tick();
      n++;
    end
    chk("wait_hold", bus.byte_flg, 1);
  endtask

  task automatic ack_n(input int k);
    for (int i = 0; i < k; i++) begin
      wait_hold();
      bus.byte_ack = 1'b1;
      tick();
      bus.byte_ack = 1'b0;
    end
  endtask

  task automatic finish_pkt(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      bus.byte_ack = bus.byte_flg;
      tick();
      bus.byte_ack = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pkt_flg"},  bus.pkt_flg, 0);
    chk({tag, "_shift_en"}, bus.shift_en, 0);
    chk({tag, "_byte_flg"}, bus.byte_flg, 0);
    chk({tag, "_irq"},      bus.irq, 0);
    chk({tag, "_done"},     bus.done, 0);
    chk({tag, "_aborted"},  bus.aborted, 0);
    chk({tag, "_overrun"},  bus.overrun, 0);
    chk({tag, "_left"},     bus.bytes_left, 0);
    chk({tag, "_state"},    bus.state_dbg, 0);
  endtask

  initial begin
    int  n_shift, n_ep;
    bit  got_done, prev_bf;
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.pkt_rec  = 1'b0;
    bus.cs       = 1'b0;
    bus.byte_ack = 1'b0;
    bus.ovr_clr  = 1'b0;
    tick();
    chk_all_zero("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single packet, ack in first HOLD cycle
    start_pkt();
    chk("t1_pkt_flg", bus.pkt_flg, 1);
    chk("t1_irq", bus.irq, 1);
    n_shift  = 0;
    n_ep     = 0;
    got_done = 1'b0;
    prev_bf  = 1'b0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      tick();
      bus.byte_ack = 1'b0;
      if (bus.pkt_flg) chk("t1_extra_load", bus.pkt_flg, 0);
      if (bus.shift_en) n_shift++;
      if (bus.byte_flg && !prev_bf) begin
        chk("t1_hold_left", bus.bytes_left, 8 - n_ep);
        n_ep++;
        bus.byte_ack = 1'b1;
      end
      prev_bf = bus.byte_flg;
      if (bus.done) begin
        got_done = 1'b1;
        chk("t1_done_lat", c, 73);
        chk("t1_done_left", bus.bytes_left, 0);
        chk("t1_done_irq", bus.irq, 0);
      end
    end
    bus.byte_ack = 1'b0;
    chk("t1_done_seen", got_done, 1);
    chk("t1_n_shift", n_shift, 64);
    chk("t1_n_hold", n_ep, 8);
    tick();
    chk("t1_done_once", bus.done, 0);

    // ack gating; cs edge before first ack ignored
    start_pkt();
    wait_hold();
    chk("t2_left8", bus.bytes_left, 8);
    bus.cs = 1'b1;
    bus.byte_ack = 1'b1;
    tick();
    bus.byte_ack = 1'b0;
    chk("t2_cs_ack_flg", bus.byte_flg, 1);
    chk("t2_cs_ack_left", bus.bytes_left, 8);
    chk("t2_early_abort", bus.aborted, 0);
    bus.cs = 1'b0;
    tick();
    chk("t2_still_hold", bus.byte_flg, 1);
    bus.byte_ack = 1'b1;
    tick();
    bus.byte_ack = 1'b0;
    chk("t2_ack_shift", bus.shift_en, 1);
    chk("t2_ack_flg", bus.byte_flg, 0);
    chk("t2_ack_left", bus.bytes_left, 7);
    bus.byte_ack = 1'b1;
    tick();
    bus.byte_ack = 1'b0;
    chk("t2_shift_ack_left", bus.bytes_left, 7);
    chk("t2_shift_ack_en", bus.shift_en, 1);
    finish_pkt("t2_done");

    // overrun during the third byte
    tick();
    start_pkt();
    ack_n(2);
    chk("t3_3rd_shift", bus.shift_en, 1);
    bus.pkt_rec = 1'b1;
    tick();
    bus.pkt_rec = 1'b0;
    chk("t3_ovr_set", bus.overrun, 1);
    chk("t3_still_shift", bus.shift_en, 1);
    chk("t3_left", bus.bytes_left, 6);
    finish_pkt("t3_done");
    chk("t3_ovr_sticky", bus.overrun, 1);
    tick();
    chk("t3_no_reload", bus.pkt_flg, 0);
    start_pkt();
    bus.pkt_rec = 1'b1;
    bus.ovr_clr = 1'b1;
    tick();
    bus.pkt_rec = 1'b0;
    chk("t3_set_wins", bus.overrun, 1);
    tick();
    bus.ovr_clr = 1'b0;
    chk("t3_clr", bus.overrun, 0);
    finish_pkt("t3b_done");

    // back-to-back on the final ack
    tick();
    start_pkt();
    ack_n(7);
    wait_hold();
    chk("t4_left1", bus.bytes_left, 1);
    bus.byte_ack = 1'b1;
    bus.pkt_rec  = 1'b1;
    tick();
    bus.byte_ack = 1'b0;
    bus.pkt_rec  = 1'b0;
    chk("t4_done", bus.done, 1);
    chk("t4_pkt_flg", bus.pkt_flg, 1);
    chk("t4_no_ovr", bus.overrun, 0);
    chk("t4_left0", bus.bytes_left, 0);
    tick();
    chk("t4_shift", bus.shift_en, 1);
    chk("t4_reload", bus.bytes_left, 8);
    finish_pkt("t4_done2");

    // abort after three acks
    tick();
    start_pkt();
    ack_n(3);
    chk("t5_left5", bus.bytes_left, 5);
    bus.cs = 1'b1;
    tick();
    chk("t5_aborted", bus.aborted, 1);
    chk("t5_irq", bus.irq, 0);
    chk("t5_idle", bus.state_dbg, 0);
    chk("t5_no_done", bus.done, 0);
    chk("t5_left0", bus.bytes_left, 0);
    tick();
    chk("t5_abort_once", bus.aborted, 0);
    chk("t5_no_done2", bus.done, 0);
    bus.cs = 1'b0;
    tick();

    // reset in HOLD with four bytes left
    start_pkt();
    ack_n(4);
    wait_hold();
    chk("t6_left4", bus.bytes_left, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("t6_rst");
    tick();
    chk("t6_no_done", bus.done, 0);
    start_pkt();
    chk("t6_load", bus.pkt_flg, 1);
    tick();
    chk("t6_left8", bus.bytes_left, 8);
    finish_pkt("t6_done");

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
